// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes,
// controller state encoding and op classifiers.
package muldiv_ctrl_pkg;

  localparam logic [4:0] OP_MFHI  = 5'b01000;
  localparam logic [4:0] OP_MTHI  = 5'b01001;
  localparam logic [4:0] OP_MFLO  = 5'b01010;
  localparam logic [4:0] OP_MTLO  = 5'b01011;
  localparam logic [4:0] OP_MULT  = 5'b01100;
  localparam logic [4:0] OP_MULTU = 5'b01101;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_DIVU  = 5'b01111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Ops that occupy the multi-cycle unit.
  function automatic logic is_md_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that touch the HI/LO registers.
  function automatic logic is_hl_op(input logic [4:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EX stage / multi-cycle unit and the sequencer.
//   EX side  : op_valid, aluop, rs_val, rt_val, flush -> stall, rd_data, div0
//   unit side: unit_start, unit_op, unit_a, unit_b -> unit_finish, unit_hi, unit_lo
//   status   : timeout_err
// slave is the sequencer, master is the surrounding pipeline/unit.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [4:0]       aluop;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             unit_start;
  logic [4:0]       unit_op;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic             unit_finish;
  logic [WIDTH-1:0] unit_hi;
  logic [WIDTH-1:0] unit_lo;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic             div0;
  logic             timeout_err;

  modport slave (
    input  op_valid, aluop, rs_val, rt_val, flush, unit_finish, unit_hi, unit_lo,
    output unit_start, unit_op, unit_a, unit_b, rd_data, stall, div0, timeout_err
  );

  modport master (
    output op_valid, aluop, rs_val, rt_val, flush, unit_finish, unit_hi, unit_lo,
    input  unit_start, unit_op, unit_a, unit_b, rd_data, stall, div0, timeout_err
  );
endinterface

// File: rtl/muldiv_watchdog.sv
// Cycle counter guarding the BUSY state.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : count this cycle
//   expire     : count has reached TIMEOUT-1
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the EX-stage ALU and the multi-cycle mul/div unit.
// Issues mult/multu/div/divu to the unit, commits its result into HI/LO,
// services mfhi/mflo/mthi/mtlo, stalls on HI/LO hazards, and recovers from
// flush, divide-by-zero and a watchdog timeout.
//   clk, rst_n : clock, async active-low reset
//   bus        : muldiv_ctrl_if slave (EX handshake, unit handshake, status)
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       op_q, op_d;
  logic             terr_q, terr_d;

  logic md, hl, accept, div_zero, wd_expire;

  assign md       = is_md_op(bus.aluop);
  assign hl       = is_hl_op(bus.aluop);
  assign accept   = bus.op_valid && md && (state_q == IDLE) && !bus.flush;
  // A zero divisor is answered on the spot and never reaches the unit.
  assign div_zero = accept && is_div_op(bus.aluop) && (bus.rt_val == '0);

  muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (state_q == BUSY),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!div_zero) begin
            op_d    = bus.aluop;
            a_d     = bus.rs_val;
            b_d     = bus.rt_val;
            state_d = BUSY;
          end
        end else if (bus.op_valid && !bus.flush) begin
          if (bus.aluop == OP_MTHI) hi_d = bus.rs_val;
          if (bus.aluop == OP_MTLO) lo_d = bus.rs_val;
        end
      end
      BUSY: begin
        // Finish beats flush and timeout: a completed result is never lost.
        if (bus.unit_finish) begin
          hi_d    = bus.unit_hi;
          lo_d    = bus.unit_lo;
          state_d = IDLE;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end else if (wd_expire) begin
          state_d = DRAIN;
          terr_d  = 1'b1;
        end
      end
      // One dead cycle with start low so the unit sees a clean restart.
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 5'b00000;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.unit_start  = (state_q == BUSY);
  assign bus.unit_op     = op_q;
  assign bus.unit_a      = a_q;
  assign bus.unit_b      = b_q;
  assign bus.stall       = (state_q != IDLE) && bus.op_valid && (md || hl);
  assign bus.div0        = div_zero;
  assign bus.rd_data     = (bus.aluop == OP_MFLO) ? lo_q : hi_q;
  assign bus.timeout_err = terr_q;

endmodule
